// File: rtl/perm_out_blk_if.sv
// Handshake bundle between the Keccak state unloader and its neighbours: memory read port,
// control strobes and the pushout/stopout/firstout/dout output stream.
interface perm_out_blk_if;
   logic        start;
   logic        busy;
   logic        done;
   logic [2:0]  mrx;
   logic [2:0]  mry;
   logic [63:0] mrd;
   logic        pushout;
   logic        stopout;
   logic        firstout;
   logic [63:0] dout;

   modport master (
      input  start, mrd, stopout,
      output busy, done, mrx, mry, pushout, firstout, dout
   );

   modport slave (
      output start, mrd, stopout,
      input  busy, done, mrx, mry, pushout, firstout, dout
   );
endinterface

// File: rtl/perm_out_blk.sv
// Streams the first OUT_LANES lanes of the final permutation state out of lane memory in
// x-fastest order, holding busy meanwhile and pulsing done after the last lane is accepted.
module perm_out_blk #(
   parameter int unsigned OUT_LANES = 25
) (
   input  logic          clk,
   input  logic          rst,
   perm_out_blk_if.master bus
);

   typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

   state_e      state_q, state_d;
   logic [2:0]  x_q, x_d;
   logic [2:0]  y_q, y_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] dout_q, dout_d;
   logic        pushout_q, pushout_d;
   logic        firstout_q, firstout_d;
   logic        done_q, done_d;
   logic        load;

   // A new lane may enter the output register when it is empty or being drained this edge.
   assign load = (state_q == StStream) && (!pushout_q || !bus.stopout);

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      cnt_d      = cnt_q;
      dout_d     = dout_q;
      pushout_d  = pushout_q;
      firstout_d = firstout_q;
      done_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StStream;
               x_d     = 3'd0;
               y_d     = 3'd0;
               cnt_d   = 5'd0;
            end
         end
         StStream: begin
            if (load) begin
               dout_d     = bus.mrd;
               pushout_d  = 1'b1;
               firstout_d = (cnt_q == 5'd0);
               cnt_d      = cnt_q + 5'd1;
               if (x_q == 3'd4) begin
                  x_d = 3'd0;
                  y_d = y_q + 3'd1;
               end else begin
                  x_d = x_q + 3'd1;
               end
               if (cnt_q + 5'd1 == 5'(OUT_LANES)) begin
                  state_d = StDrain;
                  x_d     = 3'd0;
                  y_d     = 3'd0;
               end
            end
         end
         StDrain: begin
            if (pushout_q && !bus.stopout) begin
               pushout_d  = 1'b0;
               firstout_d = 1'b0;
               done_d     = 1'b1;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         x_q        <= 3'd0;
         y_q        <= 3'd0;
         cnt_q      <= 5'd0;
         dout_q     <= 64'd0;
         pushout_q  <= 1'b0;
         firstout_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         cnt_q      <= cnt_d;
         dout_q     <= dout_d;
         pushout_q  <= pushout_d;
         firstout_q <= firstout_d;
         done_q     <= done_d;
      end
   end

   assign bus.busy     = (state_q != StIdle);
   assign bus.done     = done_q;
   assign bus.mrx      = x_q;
   assign bus.mry      = y_q;
   assign bus.pushout  = pushout_q;
   assign bus.firstout = firstout_q;
   assign bus.dout     = dout_q;

endmodule

// File: tb/tb_perm_out_blk.sv
// Bench for perm_out_blk: two instances (25 and 4 lanes) share a lane memory; a lane-queue
// reference predicts every presented lane, firstout, latency and the done edge.
module tb_perm_out_blk;

   logic        clk;
   logic        rst;
   logic        start;
   logic        stopout;
   logic        sel4;
   logic [63:0] mem_lane [25];

   int total;
   int bad;

   perm_out_blk_if b25 ();
   perm_out_blk_if b4 ();

   perm_out_blk #(.OUT_LANES(25)) u_dut25 (.clk(clk), .rst(rst), .bus(b25.master));
   perm_out_blk #(.OUT_LANES(4))  u_dut4  (.clk(clk), .rst(rst), .bus(b4.master));

   assign b25.start   = start && !sel4;
   assign b4.start    = start && sel4;
   assign b25.stopout = stopout;
   assign b4.stopout  = stopout;
   assign b25.mrd = (b25.mrx < 3'd5 && b25.mry < 3'd5) ?
                    mem_lane[int'(b25.mry) * 5 + int'(b25.mrx)] : 64'd0;
   assign b4.mrd  = (b4.mrx < 3'd5 && b4.mry < 3'd5) ?
                    mem_lane[int'(b4.mry) * 5 + int'(b4.mrx)] : 64'd0;

   logic        o_push, o_first, o_busy, o_done;
   logic [63:0] o_dout;
   logic [2:0]  o_mrx, o_mry;
   assign o_push  = sel4 ? b4.pushout  : b25.pushout;
   assign o_first = sel4 ? b4.firstout : b25.firstout;
   assign o_busy  = sel4 ? b4.busy     : b25.busy;
   assign o_done  = sel4 ? b4.done     : b25.done;
   assign o_dout  = sel4 ? b4.dout     : b25.dout;
   assign o_mrx   = sel4 ? b4.mrx      : b25.mrx;
   assign o_mry   = sel4 ? b4.mry      : b25.mry;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_random();
      for (int k = 0; k < 25; k++) mem_lane[k] = {$urandom, $urandom};
   endtask

   // mode 0: no stall, 1: 3 stalls then alternate, 2: random, 3: 100-cycle stall on last lane
   task automatic run_state(input bit use4, input int mode, input int restart_at);
      logic [63:0] exp_q [$];
      int  n, e, taken, stalls, hold, p;
      bit  seen_push, restarted, finished;
      logic so;
      n = use4 ? 4 : 25;
      sel4 = use4;
      exp_q.delete();
      for (int k = 0; k < n; k++) exp_q.push_back(mem_lane[k]);
      start = 1'b1;
      stopout = 1'b0;
      step();
      start = 1'b0;
      check("busy_after_start", o_busy, 1);
      check("addr_x_start", o_mrx, 0);
      check("addr_y_start", o_mry, 0);
      e = 0; taken = 0; stalls = 0; hold = 0; p = 0;
      seen_push = 0; restarted = 0; finished = 0;
      while (!finished && e < 400) begin
         if (o_done) begin
            check("done_edge", e, n + 1 + stalls);
            check("lane_count", taken, n);
            check("busy_at_done", o_busy, 0);
            finished = 1;
         end else begin
            check("busy", o_busy, 1);
            if (use4) begin
               check("mrx_limit", o_mrx < 3'd4, 1);
               check("mry_zero", o_mry, 0);
            end
            if (o_push) begin
               if (!seen_push) begin
                  check("first_latency", e, 1);
                  seen_push = 1;
               end
               check("lane_avail", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) check("dout", o_dout, exp_q[0]);
               check("firstout", o_first, taken == 0);
               case (mode)
                  1:       so = (p < 3) ? 1'b1 : 1'((p - 3) % 2 == 1);
                  2:       so = 1'($urandom_range(0, 1));
                  3: begin
                     so = 1'b0;
                     if (taken == n - 1 && hold < 100) begin
                        so = 1'b1;
                        hold++;
                     end
                  end
                  default: so = 1'b0;
               endcase
               p++;
               if (so) stalls++;
               else begin
                  if (exp_q.size() > 0) void'(exp_q.pop_front());
                  taken++;
               end
            end else begin
               check("firstout_idle", o_first, 0);
               so = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            stopout = so;
            if (restart_at >= 0 && !restarted && taken == restart_at) begin
               start = 1'b1;
               restarted = 1;
            end
            step();
            start = 1'b0;
            e++;
         end
      end
      check("finished", finished, 1);
      stopout = 1'b0;
      step();
      check("done_single", o_done, 0);
      check("idle_busy", o_busy, 0);
      check("idle_push", o_push, 0);
   endtask

   initial begin
      int taken;
      total = 0;
      bad = 0;
      sel4 = 1'b0;
      start = 1'b0;
      stopout = 1'b0;
      rst = 1'b0;
      for (int k = 0; k < 25; k++) mem_lane[k] = 64'((k / 5) * 16 + (k % 5));

      #2 rst = 1'b1;
      #1;
      check("rst_push", b25.pushout, 0);
      check("rst_first", b25.firstout, 0);
      check("rst_dout", b25.dout, 0);
      check("rst_done", b25.done, 0);
      check("rst_busy", b25.busy, 0);
      check("rst_mrx", b25.mrx, 0);
      check("rst_mry", b25.mry, 0);
      step();
      rst = 1'b0;
      step();
      check("idle_busy_rst", b4.busy, 0);

      run_state(0, 0, -1);
      fill_random();
      run_state(0, 1, -1);
      run_state(1, 0, -1);
      fill_random();
      run_state(1, 2, -1);
      run_state(0, 0, 10);
      run_state(0, 0, -1);

      // Reset abort while lane 12 is stalled
      sel4 = 1'b0;
      fill_random();
      start = 1'b1;
      step();
      start = 1'b0;
      taken = 0;
      for (int i = 0; i < 40; i++) begin
         if (o_push && taken == 12) break;
         if (o_push) taken++;
         step();
      end
      check("abort_reached", taken, 12);
      stopout = 1'b1;
      step();
      step();
      check("abort_stalled", o_push, 1);
      #3 rst = 1'b1;
      #1;
      check("abort_push", o_push, 0);
      check("abort_first", o_first, 0);
      check("abort_busy", o_busy, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      stopout = 1'b0;
      for (int i = 0; i < 30; i++) begin
         check("abort_no_done", o_done, 0);
         check("abort_no_push", o_push, 0);
         step();
      end
      run_state(0, 0, -1);

      run_state(0, 3, -1);
      fill_random();
      run_state(0, 2, -1);
      run_state(1, 3, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/perm_out_blk.md
# perm_out_blk

Output unloader for the Keccak permutation datapath. Once the permutation core has left its final 5x5x64 state in a lane memory, this block reads that state lane by lane and streams it out on the pushout/stopout/firstout/dout handshake: the same protocol perm_blk accepts on its input side. It holds `busy` while streaming so the core does not overwrite the memory, and pulses `done` when the last lane has been accepted downstream.

## Interface
- OUT_LANES, default 25: number of lanes emitted per state. Range 1..25. For example, 17 gives the SHA3-256 rate and 4 gives a 256-bit digest.
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request: the final state is valid in memory; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses; the memory must not be written while busy=1
- done  out  1  one-cycle pulse after the last lane transfers
- mrx  out  3  memory read lane x
- mry  out  3  memory read lane y
- mrd  in  64  memory read data; combinational, valid in the same cycle as mrx/mry
- pushout  out  1  dout/firstout valid
- stopout  in  1  downstream stall
- firstout  out  1  marks lane (0,0) of each state
- dout  out  64  lane data

## Operation
- Transfer rule: a lane transfers on a rising edge where pushout=1 and stopout=0.
- Lane order: x fastest, then y, i.e. (0,0),(1,0)..(4,0),(0,1)..(4,4). This is the order perm_blk loads m1. Only the first OUT_LANES lanes are emitted.
- Registers:
  - x, y: 3 bits each; drive mrx/mry directly
  - cnt: 5 bits, lanes loaded
  - output register: dout, pushout, firstout
- Load condition L = (state==STREAM) && (!pushout || !stopout).
- States:
  - IDLE:
    - busy=0; mrx=mry=0
    - start=1 -> STREAM with x=y=0, cnt=0
  - STREAM: on L:
    - dout<=mrd; pushout<=1; firstout<=(cnt==0); cnt<=cnt+1
    - advance (x,y): x wraps 4->0 with y+1
    - if cnt+1==OUT_LANES -> DRAIN, x=y=0
    - without L: pushout, firstout, dout, x, y and cnt all hold
  - DRAIN:
    - no loads; output register holds while stopout=1
    - when pushout && !stopout: pushout<=0, firstout<=0, done<=1 -> IDLE
- If the final lane transfers on the same edge the next lane would load, the new lane replaces it with no bubble. Throughput is 1 lane/cycle when stopout=0.
- start in STREAM or DRAIN is ignored, with no queuing. start in the same cycle as the done pulse (state is already IDLE) is accepted.
- No lane is dropped or duplicated under any stopout pattern. dout is stable while pushout=1 and stopout=1.

## Timing
- Reset values: pushout=0, firstout=0, dout=0, done=0, busy=0, mrx=mry=0, state=IDLE, cnt=0. Assertion of rst mid-stream aborts immediately. There is no partial-state resume.
- Latency, with start sampled at edge E0:
  - STREAM and busy=1 after E0; mrx=mry=0 during the following cycle
  - lane (0,0) on dout with pushout=1, firstout=1 after E1
- With stopout=0, lane k is presented after E(k+1). The last lane is presented after E(OUT_LANES) and transfers at E(OUT_LANES+1). done=1 and busy=0 are then visible for one cycle and the state is IDLE.
- Each stalled cycle adds exactly one cycle to the total.
- firstout is high only while lane (0,0) is presented. It stays high across stalls of that lane.
- done is high for exactly one cycle per state streamed. It is never asserted after a reset abort.

## Test plan
- Default OUT_LANES=25, stopout=0, memory lane (x,y)=64'h0000_0000_0000_00{y,x}, start at E0 -> 25 transfers at E2..E26, values 00,01..04,10..44 in x-fastest order; firstout only on the first; done at E26; busy low thereafter.
- stopout high for the first 3 cycles of presentation, then alternating 1/0 -> every lane exactly once, in order; dout stable during stalls; firstout held through the initial stall; total cycles = 26 + stall count.
- OUT_LANES=4 -> lanes (0,0)..(3,0) only, done at E5, mrx never exceeds 3 while streaming and mry stays 0.
- start re-pulsed during STREAM at lane 10 -> ignored; exactly 25 lanes and a single done; a new start after done restarts at (0,0) with firstout=1.
- rst asserted asynchronously while lane 12 is stalled -> pushout, firstout and busy drop immediately with no clock edge; no done; a subsequent start streams the full state from (0,0).
- stopout held high for 100 cycles on the last lane -> state stays DRAIN, busy=1, done=0; on release: one transfer, done pulses once, then IDLE.
